run_sorter: RTL and testbench

- Upstream stage of merge_phase.
- Accepts a stream of range tuples and groups them into runs of 16.
- Sorts each run in place with an odd-even transposition network, then writes the run into the even/odd bank pair as 8 rows.
- When it finishes, the banks hold sorted 16-entry runs, which is the starting condition merge_phase needs (start_width = 16).

---
 rtl/run_sorter_pkg.sv | 33 +++
 rtl/run_sorter_cmp_swap.sv | 18 +
 rtl/run_sorter.sv | 205 ++++++++++++++++++++
 tb/tb_run_sorter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_sorter_pkg.sv
// Shared types, ordering function and size defaults for run_sorter and its compare-swap cells.
package run_sorter_pkg;

  localparam int unsigned LO_WIDTH                = 16;
  localparam int unsigned HI_WIDTH                = 16;
  localparam int unsigned DEFAULT_RUN_LEN         = 16;
  localparam int unsigned DEFAULT_BANK_ADDR_WIDTH = 8;

  typedef struct packed {
    logic [LO_WIDTH-1:0] lo;
    logic [HI_WIDTH-1:0] hi;
  } tuple_pair_t;

  // All-ones tuple orders after every real entry, so padded slots sink to the end of a run.
  localparam tuple_pair_t SENTINEL = {(LO_WIDTH + HI_WIDTH){1'b1}};

  typedef enum logic [1:0] {
    StFill,
    StSort,
    StWrite,
    StDone
  } sorter_state_e;

  // Unsigned order on lo, ties broken by hi.
  function automatic logic tuple_gt(input tuple_pair_t a, input tuple_pair_t b);
    return (a.lo > b.lo) || ((a.lo == b.lo) && (a.hi > b.hi));
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_sorter_cmp_swap.sv
// Combinational compare-swap cell: orders two tuples and flags whether they were exchanged.
module run_sorter_cmp_swap
  import run_sorter_pkg::*;
(
  input  tuple_pair_t a,
  input  tuple_pair_t b,
  output tuple_pair_t min_val,
  output tuple_pair_t max_val,
  output logic        swapped
);

  always_comb begin
    swapped = tuple_gt(a, b);
    min_val = swapped ? b : a;
    max_val = swapped ? a : b;
  end

endmodule

// File: rtl/run_sorter.sv
// Groups incoming tuples into runs, sorts each run with odd-even transposition and writes it as
// even/odd bank rows. Optional swap counter enabled by RUN_SORTER_SWAPCNT_EN.
module run_sorter
  import run_sorter_pkg::*;
#(
  parameter int unsigned RUN_LEN         = DEFAULT_RUN_LEN,
  parameter int unsigned SORT_PHASES     = RUN_LEN,
  parameter int unsigned BANK_ADDR_WIDTH = DEFAULT_BANK_ADDR_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  tuple_pair_t                in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output tuple_pair_t                even_data_out,
  output tuple_pair_t                odd_data_out,
  output logic [BANK_ADDR_WIDTH-1:0] write_addr_out,
  output logic                       write_en_out,
  output logic [15:0]                run_count_out,
  output logic                       overflow_err_out,
  output logic                       done_out
`ifdef RUN_SORTER_SWAPCNT_EN
  ,
  output logic [31:0]                swap_count_out
`endif
);

  localparam int unsigned ROWS   = RUN_LEN / 2;
  localparam int unsigned IDX_W  = idx_width(RUN_LEN);
  localparam int unsigned PH_W   = idx_width(SORT_PHASES);
  localparam int unsigned BASE_W = BANK_ADDR_WIDTH + 1;
  localparam logic [BASE_W:0] BANK_ROWS = {2'b01, {BANK_ADDR_WIDTH{1'b0}}};
  localparam logic [BASE_W:0] ROW_STEP  = (BASE_W + 1)'(ROWS);

  sorter_state_e     state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  row;
  logic [PH_W-1:0]   phase;
  logic [BASE_W-1:0] base;
  logic              last_seen;

  tuple_pair_t slot      [RUN_LEN];
  tuple_pair_t sort_next [RUN_LEN];
  tuple_pair_t pair_min  [RUN_LEN-1];
  tuple_pair_t pair_max  [RUN_LEN-1];
  logic [RUN_LEN-2:0] pair_swapped;
  logic [RUN_LEN-2:0] pair_active;

  logic             fire;
  logic             fits;
  logic [IDX_W-1:0] even_sel;
  logic [IDX_W-1:0] odd_sel;

  assign fire     = in_valid && in_ready && (state == StFill);
  assign fits     = ({1'b0, base} + ROW_STEP) <= BANK_ROWS;
  assign even_sel = IDX_W'({row, 1'b0});
  assign odd_sel  = even_sel | IDX_W'(1);

  // One cell per adjacent pair; even phases use pairs starting at even slots, odd phases the rest.
  for (genvar i = 0; i < RUN_LEN - 1; i++) begin : g_pair
    run_sorter_cmp_swap u_cmp_swap (
      .a       (slot[i]),
      .b       (slot[i+1]),
      .min_val (pair_min[i]),
      .max_val (pair_max[i]),
      .swapped (pair_swapped[i])
    );
    assign pair_active[i] = (phase[0] == ((i % 2) == 1));
  end

  always_comb begin
    for (int j = 0; j < RUN_LEN; j++) begin
      sort_next[j] = slot[j];
    end
    for (int i = 0; i < RUN_LEN - 1; i++) begin
      if (pair_active[i]) begin
        sort_next[i]   = pair_min[i];
        sort_next[i+1] = pair_max[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < RUN_LEN; j++) begin
        slot[j] <= '0;
      end
    end else if (fire) begin
      for (int j = 0; j < RUN_LEN; j++) begin
        if (IDX_W'(j) == idx) begin
          slot[j] <= in_data;
        end else if (in_last && (j > int'(idx))) begin
          slot[j] <= SENTINEL;
        end
      end
    end else if (state == StSort) begin
      for (int j = 0; j < RUN_LEN; j++) begin
        slot[j] <= sort_next[j];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= StFill;
      idx              <= '0;
      row              <= '0;
      phase            <= '0;
      base             <= '0;
      last_seen        <= 1'b0;
      in_ready         <= 1'b0;
      write_en_out     <= 1'b0;
      write_addr_out   <= '0;
      even_data_out    <= '0;
      odd_data_out     <= '0;
      run_count_out    <= '0;
      overflow_err_out <= 1'b0;
      done_out         <= 1'b0;
    end else begin
      write_en_out <= 1'b0;
      unique case (state)
        StFill: begin
          in_ready <= 1'b1;
          if (fire) begin
            idx <= idx + IDX_W'(1);
            if (in_last) begin
              last_seen <= 1'b1;
            end
            if (in_last || (idx == IDX_W'(RUN_LEN - 1))) begin
              state    <= StSort;
              phase    <= '0;
              in_ready <= 1'b0;
            end
          end
        end
        StSort: begin
          phase <= phase + PH_W'(1);
          if (phase == PH_W'(SORT_PHASES - 1)) begin
            row <= '0;
            if (fits) begin
              state <= StWrite;
            end else begin
              // No room for this run: flag it and stop without touching the banks.
              overflow_err_out <= 1'b1;
              state            <= StDone;
            end
          end
        end
        StWrite: begin
          write_en_out   <= 1'b1;
          write_addr_out <= base[BANK_ADDR_WIDTH-1:0] + BANK_ADDR_WIDTH'(row);
          even_data_out  <= slot[even_sel];
          odd_data_out   <= slot[odd_sel];
          row            <= row + IDX_W'(1);
          if (row == IDX_W'(ROWS - 1)) begin
            base          <= base + BASE_W'(ROWS);
            run_count_out <= run_count_out + 16'd1;
            idx           <= '0;
            if (last_seen) begin
              state <= StDone;
            end else begin
              state    <= StFill;
              in_ready <= 1'b1;
            end
          end
        end
        StDone: begin
          in_ready <= 1'b0;
          done_out <= 1'b1;
        end
        default: state <= StFill;
      endcase
    end
  end

`ifdef RUN_SORTER_SWAPCNT_EN
  logic [31:0] phase_swaps;
  logic [32:0] swap_sum;

  always_comb begin
    phase_swaps = '0;
    for (int i = 0; i < RUN_LEN - 1; i++) begin
      if (pair_active[i] && pair_swapped[i]) begin
        phase_swaps = phase_swaps + 32'd1;
      end
    end
  end

  assign swap_sum = {1'b0, swap_count_out} + {1'b0, phase_swaps};

  // Accumulates across runs and saturates rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      swap_count_out <= '0;
    end else if (state == StSort) begin
      swap_count_out <= swap_sum[32] ? '1 : swap_sum[31:0];
    end
  end
`else
  logic unused_swaps;
  assign unused_swaps = ^pair_swapped;
`endif

endmodule

// File: tb/tb_run_sorter.sv
// Randomised self-checking bench for run_sorter against a queue-sorting reference model.
module tb_run_sorter;
  import run_sorter_pkg::*;

  localparam int unsigned RUN_LEN = 16;
  localparam int unsigned ROWS    = RUN_LEN / 2;
  localparam int unsigned PHASES  = RUN_LEN;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  tuple_pair_t in_data = '0;

  logic        in_ready, write_en, overflow_err, done;
  tuple_pair_t even_data, odd_data;
  logic [7:0]  write_addr;
  logic [15:0] run_count;

  logic        sm_in_ready, sm_write_en, sm_overflow, sm_done;
  tuple_pair_t sm_even, sm_odd;
  logic [2:0]  sm_addr;
  logic [15:0] sm_run_count;
`ifdef RUN_SORTER_SWAPCNT_EN
  logic [31:0] swap_count, sm_swap_count;
`endif

  run_sorter #(.RUN_LEN(RUN_LEN), .BANK_ADDR_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .even_data_out(even_data), .odd_data_out(odd_data),
    .write_addr_out(write_addr), .write_en_out(write_en), .run_count_out(run_count),
    .overflow_err_out(overflow_err), .done_out(done)
`ifdef RUN_SORTER_SWAPCNT_EN
    , .swap_count_out(swap_count)
`endif
  );

  run_sorter #(.RUN_LEN(RUN_LEN), .BANK_ADDR_WIDTH(3)) dut_small (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(sm_in_ready), .even_data_out(sm_even), .odd_data_out(sm_odd),
    .write_addr_out(sm_addr), .write_en_out(sm_write_en), .run_count_out(sm_run_count),
    .overflow_err_out(sm_overflow), .done_out(sm_done)
`ifdef RUN_SORTER_SWAPCNT_EN
    , .swap_count_out(sm_swap_count)
`endif
  );

  typedef struct {
    int          addr;
    logic [31:0] e;
    logic [31:0] o;
    int          cyc;
  } wr_rec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          log_base = 0;
  int          sm_base = 0;
  wr_rec_t     wr_log[$];
  wr_rec_t     sm_log[$];
  tuple_pair_t sent[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (write_en) wr_log.push_back('{addr: int'(write_addr), e: even_data, o: odd_data, cyc: cyc});
    if (sm_write_en) sm_log.push_back('{addr: int'(sm_addr), e: sm_even, o: sm_odd, cyc: cyc});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic tuple_pair_t rand_tuple();
    tuple_pair_t t;
    t.lo = 16'($urandom_range(0, 31));
    t.hi = 16'($urandom_range(0, 65534));
    return t;
  endfunction

  task automatic apply_reset(input string tag);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    reset    = 1'b1;
    #1;
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".write_en"}, write_en, 0);
    check({tag, ".addr"}, write_addr, 0);
    check({tag, ".data"}, {even_data, odd_data}, 0);
    check({tag, ".status"}, {run_count, overflow_err, done}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check({tag, ".ready_pre"}, in_ready, 0);
    @(negedge clock);
    check({tag, ".ready_post"}, in_ready, 1);
    sent.delete();
    log_base = wr_log.size();
    sm_base  = sm_log.size();
  endtask

  task automatic send_beat(input tuple_pair_t d, input logic last, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      check("send.ready_timeout", in_ready, 1);
    end else begin
      @(negedge clock);
      accept_cyc = cyc;
      sent.push_back(d);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 500) begin
      @(negedge clock);
      n++;
    end
    check({tag, ".done"}, done, 1);
  endtask

  // Reference: chunk the accepted beats into runs, pad with SENTINEL, sort, then expect
  // sorted pairs at consecutive rows starting from address 0.
  task automatic check_runs(input string tag);
    logic [31:0] keys[$];
    int n_runs = (sent.size() + RUN_LEN - 1) / RUN_LEN;
    check({tag, ".rows"}, wr_log.size() - log_base, n_runs * ROWS);
    for (int k = 0; k < n_runs; k++) begin
      keys.delete();
      for (int j = 0; j < RUN_LEN; j++) begin
        if (k * RUN_LEN + j < sent.size()) keys.push_back(sent[k * RUN_LEN + j]);
        else keys.push_back(SENTINEL);
      end
      keys.sort();
      for (int r = 0; r < ROWS; r++) begin
        int li = log_base + k * ROWS + r;
        if (li < wr_log.size()) begin
          check($sformatf("%s.r%0d.addr", tag, k * ROWS + r), wr_log[li].addr, k * ROWS + r);
          check($sformatf("%s.r%0d.even", tag, k * ROWS + r), wr_log[li].e, keys[2 * r]);
          check($sformatf("%s.r%0d.odd", tag, k * ROWS + r), wr_log[li].o, keys[2 * r + 1]);
        end
      end
    end
  endtask

  initial begin
    tuple_pair_t t;
    tuple_pair_t tie_beats[$];
    int w;
    int n;

    #2;
    apply_reset("por");

    // Descending keys: rows must come out fully reversed.
    for (int i = 0; i < 16; i++) begin
      t.lo = 16'(15 - i);
      t.hi = 16'(16 - i);
      send_beat(t, i == 15, w);
    end
    wait_done("desc");
    check("desc.rows", wr_log.size() - log_base, ROWS);
    if (wr_log.size() - log_base >= 1)
      check("desc.latency", wr_log[log_base].cyc - accept_cyc, PHASES + 1);
    for (int r = 0; r < ROWS; r++) begin
      if (log_base + r < wr_log.size()) begin
        check($sformatf("desc.r%0d.addr", r), wr_log[log_base + r].addr, r);
        check($sformatf("desc.r%0d.even", r), wr_log[log_base + r].e, {16'(2 * r), 16'(2 * r + 1)});
        check($sformatf("desc.r%0d.odd", r), wr_log[log_base + r].o,
              {16'(2 * r + 1), 16'(2 * r + 2)});
      end
    end
    check("desc.run_count", run_count, 1);
    check("desc.overflow", overflow_err, 0);
    check("desc.ready_done", in_ready, 0);

    // 40 random beats: two full runs plus a padded third.
    apply_reset("rst2");
    for (int i = 0; i < 40; i++) send_beat(rand_tuple(), i == 39, w);
    wait_done("rand40");
    check_runs("rand40");
    check("rand40.run_count", run_count, 3);
    if (log_base + 23 < wr_log.size())
      check("rand40.pad", {wr_log[log_base + 23].e, wr_log[log_base + 23].o}, {SENTINEL, SENTINEL});
    check("rand40.sm_status", {sm_overflow, sm_done, sm_run_count}, {2'b11, 16'd1});

    // Tie-breaking on hi within equal lo.
    apply_reset("rst3");
    for (int i = 0; i < 13; i++) begin
      t.lo = 16'd1;
      t.hi = 16'($urandom_range(0, 65534));
      tie_beats.push_back(t);
    end
    t.lo = 16'd5; t.hi = 16'd9; tie_beats.insert(2, t);
    t.lo = 16'd5; t.hi = 16'd3; tie_beats.insert(7, t);
    t.lo = 16'd5; t.hi = 16'd7; tie_beats.insert(11, t);
    for (int i = 0; i < 16; i++) send_beat(tie_beats[i], i == 15, w);
    wait_done("ties");
    check_runs("ties");
    if (log_base + 7 < wr_log.size()) begin
      check("ties.slot13", wr_log[log_base + 6].o, {16'd5, 16'd3});
      check("ties.slot14", wr_log[log_base + 7].e, {16'd5, 16'd7});
      check("ties.slot15", wr_log[log_base + 7].o, {16'd5, 16'd9});
    end

    // Beat 17 held valid across SORT/WRITE must stall exactly that long and be taken once.
    apply_reset("rst4");
    for (int i = 0; i < 32; i++) begin
      send_beat(rand_tuple(), i == 31, w);
      if (i == 16) check("hold.stall_cycles", w, PHASES + ROWS);
    end
    wait_done("hold");
    check_runs("hold");
    check("hold.run_count", run_count, 2);

    // Two runs into a 3-bit bank: second run overflows on the small instance.
    apply_reset("rst5");
    for (int i = 0; i < 32; i++) send_beat(rand_tuple(), i == 31, w);
    wait_done("ovf");
    check_runs("ovf");
    check("ovf.big_status", {overflow_err, run_count}, {1'b0, 16'd2});
    check("ovf.sm_status", {sm_overflow, sm_done, sm_run_count}, {2'b11, 16'd1});
    check("ovf.sm_rows", sm_log.size() - sm_base, ROWS);
    for (int r = 0; r < ROWS; r++) begin
      if (sm_base + r < sm_log.size() && log_base + r < wr_log.size()) begin
        check($sformatf("ovf.sm_r%0d.addr", r), sm_log[sm_base + r].addr, r);
        check($sformatf("ovf.sm_r%0d.data", r), {sm_log[sm_base + r].e, sm_log[sm_base + r].o},
              {wr_log[log_base + r].e, wr_log[log_base + r].o});
      end
    end

    // Reset in the middle of WRITE, then a fresh run must start at row 0.
    apply_reset("rst6");
    for (int i = 0; i < 16; i++) send_beat(rand_tuple(), 1'b0, w);
    n = 0;
    while (!(write_en && write_addr == 8'd3) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("midrst.row3_seen", write_addr, 3);
    apply_reset("midrst");
    for (int i = 0; i < 16; i++) send_beat(rand_tuple(), i == 15, w);
    wait_done("fresh");
    check_runs("fresh");
    check("fresh.run_count", run_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
